// File: rtl/uart_rx_pkg.sv
// Shared UART receive-side definitions: FSM state encoding and oversampling constants.
// PARITY is always present so the encoding does not change with the parity build option.
package UartPack;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } RxState;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 7;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Generic first-word-fall-through FIFO; head is visible the cycle after the push edge.
// Push into a full FIFO is accepted only when a pop happens in the same cycle; pop when empty is ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_head_vld,
  output logic [CW-1:0]    o_count,
  output logic [CW-1:0]    o_count_nxt,
  output logic             o_push_acc
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_head_vld  = (r_count != '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_do_pop    = i_pop && o_head_vld;
  // A full FIFO frees the head slot on a simultaneous pop, so the push can land there.
  assign w_do_push   = i_push && (!w_full || w_do_pop);
  assign o_push_acc  = w_do_push;
  assign o_count     = r_count;
  assign o_count_nxt = r_count + CW'(w_do_push) - CW'(w_do_pop);
  assign o_head_dat  = o_head_vld ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= o_count_nxt;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, bytes buffered in an FWFT FIFO drained by valid/ready; rts is registered flow control.
// Never stalls on rts: a byte arriving at a full FIFO without a pop is dropped (overrun). Build option: UART_RX_PARITY_EN.
module uart_rx
  import UartPack::*;
#(
  parameter int TICK_DIV   = 54,
  parameter int FIFO_DEPTH = 16,
  parameter int RTS_MARGIN = 4,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rxd,
  output logic          rts,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [CW-1:0] fifo_count,
  output logic          overrun,
  output logic          frame_err,
`ifdef UART_RX_PARITY_EN
  output logic          parity_err,
`endif
  input  logic          clr_err
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic          r_rx_meta;
  logic          r_rxs;
  logic [TW-1:0] r_tick_cnt;
  RxState        r_state;
  logic [3:0]    r_tc;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_rts;
  logic          r_overrun;
  logic          r_frame_err;

  logic          w_tick;
  logic          w_start;
  logic          w_mid;
  logic          w_end;
  logic          w_push;
  logic          w_push_acc;
  logic          w_ovr_set;
  logic          w_frame_set;
  logic          w_par_bad;
  logic [CW-1:0] w_count_nxt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rxd;
      r_rxs     <= r_rx_meta;
    end
  end

  assign w_tick  = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_start = (r_state == IDLE) && !r_rxs;

  // Reloading on the start edge aligns every later sample point to the falling edge of the start bit.
  always_ff @(posedge clk) begin
    if (!rstn || w_start) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  assign w_mid = w_tick && (r_tc == 4'(SAMPLE_MID));
  assign w_end = w_tick && (r_tc == 4'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_tc    <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      if (w_tick) begin
        r_tc <= r_tc + 4'd1;
      end
      case (r_state)
        IDLE: begin
          if (!r_rxs) begin
            r_state <= START;
            r_tc    <= '0;
          end
        end
        START: begin
          if (w_mid) begin
            r_tc <= '0;
            if (!r_rxs) begin
              r_state <= DATA;
              r_bit   <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        DATA: begin
          if (w_end) begin
            r_shift <= {r_rxs, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_end) begin
            r_state <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_end) begin
            r_state <= r_rxs ? IDLE : WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (r_rxs) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;
  logic w_par_set;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign w_par_set = (r_state == PARITY) && w_end && ((^r_shift) != r_rxs);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if ((r_state == PARITY) && w_end) begin
        r_par_bad <= w_par_set;
      end
      r_parity_err <= w_par_set || (r_parity_err && !clr_err);
    end
  end

  assign w_par_bad  = r_par_bad;
  assign parity_err = r_parity_err;
`else
  assign w_par_bad = 1'b0;
`endif

  assign w_push      = (r_state == STOP) && w_end && r_rxs && !w_par_bad;
  assign w_frame_set = (r_state == STOP) && w_end && !r_rxs;
  assign w_ovr_set   = w_push && !w_push_acc;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_rts       <= 1'b1;
    end else begin
      r_overrun   <= w_ovr_set || (r_overrun && !clr_err);
      r_frame_err <= w_frame_set || (r_frame_err && !clr_err);
      r_rts       <= ((CW'(FIFO_DEPTH) - w_count_nxt) <= CW'(RTS_MARGIN));
    end
  end

  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign rts       = r_rts;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .i_push      (w_push),
    .i_push_dat  (r_shift),
    .i_pop       (rx_ready),
    .o_head_dat  (rx_data),
    .o_head_vld  (rx_valid),
    .o_count     (fifo_count),
    .o_count_nxt (w_count_nxt),
    .o_push_acc  (w_push_acc)
  );

endmodule
